corefifo_rd_ctrl: RTL

- Read-side controller for the asynchronous CoreFIFO in the CORDICFIFO wrapper; runs entirely in the read clock domain.
- Synchronises the write-domain Gray pointer and converts it to binary.
- Keeps the binary and Gray read pointers, sequences reads from the dual-port RAM and presents first-word-fall-through (FWFT) data with a valid/ready handshake.
- Produces the read-domain status flags: empty, almost_empty, underflow and word count.

---
 rtl/corefifo_pkg.sv | 22 ++
 rtl/corefifo_grayToBinConv.sv | 23 ++
 rtl/corefifo_rd_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/corefifo_pkg.sv
// Shared definitions for the CoreFIFO read/write controllers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package corefifo_pkg;

  // Synchroniser depth used when the instantiating wrapper does not override it.
  localparam int DEFAULT_SYNC_STAGES = 2;

  // Widest pointer the Gray helper handles; callers truncate to their own width.
  localparam int GRAY_MAX_W = 32;

  // Pointers carry one extra MSB beyond the RAM address so that full and
  // empty can be told apart when the low address bits match.
  function automatic int ptr_width(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/corefifo_grayToBinConv.sv
// Gray-to-binary pointer converter, purely combinational.
// Latency: 0 cycles.
// Backpressure: none; output follows input.
//
// Ports:
//   gray_i  Gray-coded pointer, ADDRWIDTH+1 bits
//   bin_o   binary equivalent, ADDRWIDTH+1 bits
module corefifo_grayToBinConv #(
  parameter int ADDRWIDTH = 3
) (
  input  logic [ADDRWIDTH:0] gray_i,
  output logic [ADDRWIDTH:0] bin_o
);

  // Binary bit i is the XOR of all Gray bits from i up to the MSB.
  always_comb begin
    bin_o = '0;
    for (int i = 0; i <= ADDRWIDTH; i++) begin
      bin_o[i] = ^(gray_i >> i);
    end
  end

endmodule

// File: rtl/corefifo_rd_ctrl.sv
// Read-side controller of the async CoreFIFO: pointer sync, RAM read sequencing, FWFT output, status flags.
// Latency: write pointer visible after SYNC_STAGES cycles, rdcnt/ram_ren one cycle later, dout_valid one cycle after that.
// Backpressure: dout_valid/dout_ready handshake; RAM fetches stall while dout is held and not accepted.
//
// Ports:
//   rclk, rrst_n        read clock, async active-low reset
//   wptr_gray           Gray write pointer from the write domain (unsynchronised)
//   rptr_gray           registered Gray read pointer to the write domain
//   ram_raddr/ram_ren   dual-port RAM read address / enable
//   ram_rdata           RAM read data, one-cycle latency, held while ram_ren=0
//   dout/dout_valid     FWFT output word and its valid
//   dout_ready          consumer accepts dout this cycle
//   empty               !dout_valid
//   almost_empty        registered (RAM words + output word) <= AEVAL
//   rdcnt               words in RAM not yet fetched into dout
//   underflow           one-cycle pulse after a ready with no valid word
module corefifo_rd_ctrl
  import corefifo_pkg::*;
#(
  parameter int ADDRWIDTH   = 3,
  parameter int WIDTH       = 18,
  parameter int AEVAL       = 1,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic [ADDRWIDTH:0]   wptr_gray,
  output logic [ADDRWIDTH:0]   rptr_gray,
  output logic [ADDRWIDTH-1:0] ram_raddr,
  output logic                 ram_ren,
  input  logic [WIDTH-1:0]     ram_rdata,
  output logic [WIDTH-1:0]     dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 empty,
  output logic                 almost_empty,
  output logic [ADDRWIDTH:0]   rdcnt,
  output logic                 underflow
);

  localparam int PW = ptr_width(ADDRWIDTH);
  // A single flop is not a synchroniser; never go below two stages.
  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic [PW:0] AEVAL_W = (PW+1)'(AEVAL);

  // ---------------------------------------------------------------------------
  // Write-pointer synchroniser
  // ---------------------------------------------------------------------------
  logic [PW-1:0] wsync_gray;
  logic [PW-1:0] wsync_bin;

  for (genvar g = 0; g < SS; g++) begin : g_sync
    (* async_reg = "true" *) logic [PW-1:0] q;
    logic [PW-1:0] d;

    if (g == 0) begin : g_first
      assign d = wptr_gray;
    end else begin : g_rest
      assign d = g_sync[g-1].q;
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
        q <= '0;
      end else begin
        q <= d;
      end
    end
  end

  assign wsync_gray = g_sync[SS-1].q;

  corefifo_grayToBinConv #(
    .ADDRWIDTH (ADDRWIDTH)
  ) u_wsync_g2b (
    .gray_i (wsync_gray),
    .bin_o  (wsync_bin)
  );

  // ---------------------------------------------------------------------------
  // Read pointer, occupancy and output-stage state
  // ---------------------------------------------------------------------------
  logic [PW-1:0] rptr_bin_q,  rptr_bin_d;
  logic [PW-1:0] rptr_gray_q, rptr_gray_d;
  logic [PW-1:0] rdcnt_q,     rdcnt_d;
  logic          dout_valid_q, dout_valid_d;
  logic          almost_empty_q, almost_empty_d;
  logic          underflow_q,  underflow_d;
  logic          mem_nempty;
  logic          ren_c;
  logic [PW:0]   occ_d;

  assign mem_nempty = (rdcnt_q != '0);
  // Fetch whenever the RAM has a word and the output slot is free or being
  // vacated this cycle; this gives back-to-back reads at full rate.
  assign ren_c = mem_nempty & (~dout_valid_q | dout_ready);

  always_comb begin
    rptr_bin_d  = ren_c ? (rptr_bin_q + PW'(1)) : rptr_bin_q;
    rptr_gray_d = PW'(bin2gray(GRAY_MAX_W'(rptr_bin_d)));

    // Counting against the next read pointer keeps rdcnt consistent with the
    // fetch that is happening now, so the same word is never fetched twice.
    // Modular subtraction absorbs the pointer MSB wrap.
    rdcnt_d = wsync_bin - rptr_bin_d;

    if (ren_c) begin
      dout_valid_d = 1'b1;
    end else if (dout_ready) begin
      dout_valid_d = 1'b0;
    end else begin
      dout_valid_d = dout_valid_q;
    end

    occ_d          = {1'b0, rdcnt_d} + {{PW{1'b0}}, dout_valid_d};
    almost_empty_d = (occ_d <= AEVAL_W);
    underflow_d    = dout_ready & ~dout_valid_q;
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rptr_bin_q     <= '0;
      rptr_gray_q    <= '0;
      rdcnt_q        <= '0;
      dout_valid_q   <= 1'b0;
      almost_empty_q <= 1'b1;
      underflow_q    <= 1'b0;
    end else begin
      rptr_bin_q     <= rptr_bin_d;
      rptr_gray_q    <= rptr_gray_d;
      rdcnt_q        <= rdcnt_d;
      dout_valid_q   <= dout_valid_d;
      almost_empty_q <= almost_empty_d;
      underflow_q    <= underflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rptr_gray    = rptr_gray_q;
  assign ram_raddr    = rptr_bin_q[ADDRWIDTH-1:0];
  assign ram_ren      = ren_c;
  // The RAM holds its read data while not enabled, so it doubles as the
  // output register.
  assign dout         = ram_rdata;
  assign dout_valid   = dout_valid_q;
  assign empty        = ~dout_valid_q;
  assign almost_empty = almost_empty_q;
  assign rdcnt        = rdcnt_q;
  assign underflow    = underflow_q;

endmodule
